// File: rtl/voice_gen.sv
// rtl/voice_gen.sv - phase-accumulator voice with selectable waveform, hard sync and linear envelope
module voice_gen #(
    parameter int ACC_WIDTH  = 24,
    parameter int FREQ_WIDTH = 16,
    parameter int PW_WIDTH   = 12,
    parameter int OUT_WIDTH  = 8,
    parameter int ENV_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [FREQ_WIDTH-1:0] frequency,
    input  logic [PW_WIDTH-1:0]   pulsewidth,
    input  logic [1:0]            wave_sel,
    input  logic                  sync_in,
    input  logic                  gate,
    input  logic [ENV_WIDTH-1:0]  attack_rate,
    input  logic [ENV_WIDTH-1:0]  release_rate,
    output logic [OUT_WIDTH-1:0]  sample_out,
    output logic                  wrap_out,
    output logic [ENV_WIDTH-1:0]  env_level,
    output logic                  env_active
);

    localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;

    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;

    env_state_t             state, state_next;
    logic [ENV_WIDTH-1:0]   level_next;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH:0]     acc_sum;
    logic                   carry;
    logic [22:0]            lfsr;
    logic [22:0]            lfsr_next;
    logic [OUT_WIDTH-1:0]   raw, raw_next;
    logic [OUT_WIDTH-1:0]   p, q;
    logic [ENV_WIDTH:0]     att_sum, rel_diff;

    assign acc_sum   = {1'b0, acc} + {{(ACC_WIDTH+1-FREQ_WIDTH){1'b0}}, frequency};
    assign carry     = acc_sum[ACC_WIDTH];
    assign lfsr_next = {lfsr[21:0], lfsr[22] ^ lfsr[17]};
    assign p         = acc[ACC_WIDTH-1 -: OUT_WIDTH];
    assign q         = acc[ACC_WIDTH-2 -: OUT_WIDTH];
    assign att_sum   = {1'b0, env_level} + {1'b0, attack_rate};
    assign rel_diff  = {1'b0, env_level} - {1'b0, release_rate};
    assign env_active = (state != IDLE);

    // Waveform selection from the current phase and noise register
    always_comb begin
        raw_next = '0;
        case (wave_sel)
            2'd0:    raw_next = {OUT_WIDTH{acc[ACC_WIDTH-1 -: PW_WIDTH] >= pulsewidth}};
            2'd1:    raw_next = p;
            2'd2:    raw_next = acc[ACC_WIDTH-1] ? ~q : q;
            default: raw_next = lfsr[22 -: OUT_WIDTH];
        endcase
    end

    // Envelope next state and level; saturation done in ENV_WIDTH+1 bits
    always_comb begin
        state_next = state;
        level_next = env_level;
        case (state)
            IDLE: begin
                level_next = '0;
                if (gate) state_next = ATTACK;
            end
            ATTACK: begin
                if (!gate) begin
                    state_next = RELEASE;
                end else if (att_sum >= {1'b0, ENV_MAX}) begin
                    level_next = ENV_MAX;
                    state_next = SUSTAIN;
                end else begin
                    level_next = att_sum[ENV_WIDTH-1:0];
                end
            end
            SUSTAIN: begin
                level_next = ENV_MAX;
                if (!gate) state_next = RELEASE;
            end
            default: begin
                if (gate) begin
                    state_next = ATTACK;
                end else if (rel_diff[ENV_WIDTH] || rel_diff == '0) begin
                    level_next = '0;
                    state_next = IDLE;
                end else begin
                    level_next = rel_diff[ENV_WIDTH-1:0];
                end
            end
        endcase
    end

    // Envelope state and level registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            env_level <= '0;
        end else if (en) begin
            state     <= state_next;
            env_level <= level_next;
        end
    end

    // Phase accumulator, wrap pulse and noise LFSR; sync overrides wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            wrap_out <= 1'b0;
            lfsr     <= 23'h7FFFFF;
        end else if (en) begin
            if (sync_in) begin
                acc      <= '0;
                wrap_out <= 1'b0;
            end else begin
                acc      <= acc_sum[ACC_WIDTH-1:0];
                wrap_out <= carry;
                if (carry) lfsr <= lfsr_next;
            end
        end
    end

    // Waveform and enveloped output pipeline, each one en-cycle behind its source
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw        <= '0;
            sample_out <= '0;
        end else if (en) begin
            raw        <= raw_next;
            sample_out <= OUT_WIDTH'(({{ENV_WIDTH{1'b0}}, raw} * {{OUT_WIDTH{1'b0}}, env_level}) >> ENV_WIDTH);
        end
    end

endmodule
